// File: rtl/uart_alu_intf.sv
// rtl/uart_alu_intf.sv - UART byte collector driving an ALU and returning its result to the UART transmitter
// Optional inter-byte / tx-completion timeout enabled by UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  tx_done,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  overrun,
    output logic                  err
);

    typedef enum logic [4:0] {
        WAIT_A  = 5'b00001,
        WAIT_B  = 5'b00010,
        WAIT_OP = 5'b00100,
        SEND    = 5'b01000,
        WAIT_TX = 5'b10000
    } state_t;

    state_t                state, state_next;
    logic                  rx_done_q, tx_done_q;
    logic                  rx_evt, tx_evt;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] alu_a_next, alu_b_next, tx_data_next;
    logic [OP_WIDTH-1:0]   alu_op_next;
    logic                  tx_start_next, overrun_next;

    // Flags are levels; only the rising edge counts as an event.
    assign rx_evt = rx_done & ~rx_done_q;
    assign tx_evt = tx_done & ~tx_done_q;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting = (state == WAIT_B) || (state == WAIT_OP) || (state == WAIT_TX);
    // Firing one count early makes err rise on the edge the counter would reach TIMEOUT_CYCLES-1.
    assign timeout = waiting && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= timeout;
            if (state_next != state || !waiting)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        alu_a_next    = alu_a;
        alu_b_next    = alu_b;
        alu_op_next   = alu_op;
        tx_data_next  = tx_data;
        tx_start_next = 1'b0;
        overrun_next  = overrun;
        case (state)
            WAIT_A: begin
                if (rx_evt) begin
                    alu_a_next = rx_data;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (timeout) begin
                    state_next = WAIT_A;
                end else if (rx_evt) begin
                    alu_b_next = rx_data;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (timeout) begin
                    state_next = WAIT_A;
                end else if (rx_evt) begin
                    alu_op_next = rx_data[OP_WIDTH-1:0];
                    state_next  = SEND;
                end
            end
            SEND: begin
                tx_data_next  = alu_result;
                tx_start_next = 1'b1;
                state_next    = WAIT_TX;
                if (rx_evt)
                    overrun_next = 1'b1;
            end
            WAIT_TX: begin
                if (timeout) begin
                    state_next = WAIT_A;
                end else begin
                    if (tx_evt)
                        state_next = WAIT_A;
                    if (rx_evt)
                        overrun_next = 1'b1;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    // Done-flag history resets high so a flag already asserted at release is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_A;
            rx_done_q <= 1'b1;
            tx_done_q <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            rx_done_q <= rx_done;
            tx_done_q <= tx_done;
            alu_a     <= alu_a_next;
            alu_b     <= alu_b_next;
            alu_op    <= alu_op_next;
            tx_data   <= tx_data_next;
            tx_start  <= tx_start_next;
            overrun   <= overrun_next;
        end
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// tb/tb_uart_alu_intf.sv - directed self-checking bench for uart_alu_intf
module tb_uart_alu_intf;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int HOLD = 10;
`else
    localparam int HOLD = 50;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, overrun, err;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int err_pulses = 0;

    uart_alu_intf #(
        .DATA_WIDTH(8),
        .OP_WIDTH(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .alu_result(alu_result),
        .tx_done(tx_done),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .overrun(overrun),
        .err(err)
    );

    always #5 clk = ~clk;

    // Bench ALU: 0x20 add, 0x22 sub, 8-bit wrap.
    assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b :
                        (alu_op == 6'h22) ? alu_a - alu_b : 8'h00;

    always @(negedge clk) begin
        if (tx_start) pulses++;
        if (err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        tick();
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] op, input int hold, input logic [7:0] exp);
        int p0;
        int n;
        tick();
        rx_data = op;
        rx_done = 1'b1;
        p0 = pulses;
        n = (hold > 3) ? hold : 3;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == hold) rx_done = 1'b0;
            if (i == 1) check("tx_start_k", tx_start, 1'b0);
            if (i == 2) begin
                check("tx_start_k1", tx_start, 1'b1);
                check("tx_data", tx_data, exp);
            end
            if (i == 3) check("tx_start_k2", tx_start, 1'b0);
        end
        check("tx_pulse_count", pulses - p0, 1);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int hold, input logic [7:0] exp);
        send_byte(a, hold);
        send_byte(b, hold);
        send_op(op, hold, exp);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_op, op[5:0]);
    endtask

    task automatic finish_tx();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_a"}, alu_a, 8'h00);
        check({tag, "_alu_b"}, alu_b, 8'h00);
        check({tag, "_alu_op"}, alu_op, 6'h00);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Basic frame
        frame(8'h05, 8'h03, 8'h20, 1, 8'h08);
        check("basic_overrun", overrun, 1'b0);
        finish_tx();

        // Level-held rx_done
        frame(8'h0A, 8'h04, 8'h22, HOLD, 8'h06);
        check("level_overrun", overrun, 1'b0);
        finish_tx();

        // Overrun in WAIT_TX
        frame(8'h05, 8'h03, 8'h20, 1, 8'h08);
        send_byte(8'h77, 1);
        tick();
        check("overrun_set", overrun, 1'b1);
        check("overrun_alu_a", alu_a, 8'h05);
        finish_tx();
        frame(8'h01, 8'h01, 8'h20, 1, 8'h02);
        check("overrun_sticky", overrun, 1'b1);
        finish_tx();

        // Reset mid-frame with rx_done held across release
        send_byte(8'h09, 1);
        send_byte(8'h02, 1);
        tick();
        rx_data = 8'h33;
        rx_done = 1'b1;
        reset   = 1'b1;
        #1;
        check_zero("midreset");
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("held_no_capture", alu_a, 8'h00);
        rx_done = 1'b0;
        tick();
        frame(8'h02, 8'h02, 8'h20, 1, 8'h04);
        finish_tx();

        // Wrap-around results
        frame(8'hFF, 8'h01, 8'h20, 1, 8'h00);
        finish_tx();
        frame(8'h00, 8'h01, 8'h22, 1, 8'hFF);
        finish_tx();

`ifdef UART_ALU_INTF_TIMEOUT_EN
        send_byte(8'h05, 1);
        repeat (14) tick();
        check("timeout_err_early", err, 1'b0);
        tick();
        check("timeout_err_pulse", err, 1'b1);
        tick();
        check("timeout_err_clear", err, 1'b0);
        check("timeout_alu_a_kept", alu_a, 8'h05);
        frame(8'h01, 8'h02, 8'h20, 1, 8'h03);
        finish_tx();
        check("err_pulse_total", err_pulses, 1);
`else
        send_byte(8'h05, 1);
        repeat (40) tick();
        check("no_timeout_err", err, 1'b0);
        send_byte(8'h07, 1);
        send_op(8'h20, 1, 8'h0C);
        check("wait_b_alu_a", alu_a, 8'h05);
        check("wait_b_alu_b", alu_b, 8'h07);
        finish_tx();
        check("err_pulse_total", err_pulses, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_alu_intf.md
Name: uart_alu_intf

Overview:
- Downstream consumer of the UART receiver.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them as registered operands to a combinational ALU.
- Captures the ALU result and hands it to the UART transmitter with a one-cycle start pulse, then waits for transmit completion before accepting the next frame.

Parameters:
DATA_WIDTH, 8, width of operands, result and UART data byte
OP_WIDTH, 6, opcode width; taken from rx_data[OP_WIDTH-1:0]
TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes or for tx completion (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_data  input  DATA_WIDTH  received byte from UART receiver
rx_done  input  1  receiver done flag (level; may stay high for many cycles)
alu_result  input  DATA_WIDTH  combinational ALU result
tx_done  input  1  transmitter done flag (level)
alu_a  output  DATA_WIDTH  registered operand A
alu_b  output  DATA_WIDTH  registered operand B
alu_op  output  OP_WIDTH  registered opcode
tx_data  output  DATA_WIDTH  registered byte to transmit
tx_start  output  1  one-cycle transmit request
overrun  output  1  sticky: a byte arrived while busy and was dropped
err  output  1  one-cycle timeout pulse (0 without the optional feature)

Behaviour:
- Reset (async, active-high): state=WAIT_A. All outputs are 0. Internal rx_done_q and tx_done_q are set to 1, so a flag already high at reset release is not counted as an event.
- Byte event: rx_done & ~rx_done_q, where rx_done_q is registered every clk.
  - Acted on at the same edge where rx_done is first sampled high.
  - A flag held high yields exactly one event.
- Tx event: tx_done & ~tx_done_q, same scheme.
- States (one-hot, 5 states), transitions:
  - WAIT_A: on byte event, alu_a<=rx_data, go WAIT_B.
  - WAIT_B: on byte event, alu_b<=rx_data, go WAIT_OP.
  - WAIT_OP: on byte event, alu_op<=rx_data[OP_WIDTH-1:0], go SEND.
  - SEND (exactly 1 cycle): tx_data<=alu_result, tx_start<=1, go WAIT_TX.
  - WAIT_TX: tx_start<=0. On tx event, go WAIT_A.
  - Any illegal encoding: go WAIT_A at the next edge. Registers are unchanged.
- Latency: opcode captured at edge k; tx_start high from edge k+1 to edge k+2, exactly one cycle. tx_data is valid from edge k+1 and held until the next SEND.
- alu_a, alu_b and alu_op hold their values until overwritten by the next frame. They are never cleared except by reset.
- Byte event in SEND or WAIT_TX: byte dropped, overrun<=1. overrun is sticky until reset.
- Tx event outside WAIT_TX: ignored.
- Simultaneous byte event and tx event in WAIT_TX: the tx event is honoured (go WAIT_A), the byte is dropped and overrun is set.
- Reset mid-frame: partial operands are discarded (outputs return to 0) and the FSM restarts at WAIT_A.

Optional Feature:
- Macro UART_ALU_INTF_TIMEOUT_EN.
- Defined:
  - Counter of width clog2(TIMEOUT_CYCLES), cleared on every state change and on reset.
  - Increments each cycle in WAIT_B, WAIT_OP and WAIT_TX.
  - On reaching TIMEOUT_CYCLES-1: go WAIT_A, err=1 for one cycle, tx_start=0. alu_a, alu_b and alu_op are left unchanged.
  - A byte event on the same cycle as the timeout is dropped. overrun is not set.
- Undefined: no counter exists, err is tied to 0, and the FSM may wait indefinitely.

Test Plan:
- Basic frame: reset; bench ALU models op 0x20=add, 0x22=sub. Send rx_data 0x05, 0x03, 0x20 as rx_done pulses. Expect alu_a=0x05, alu_b=0x03, alu_op=0x20, a single tx_start pulse one cycle after the opcode edge, tx_data=0x08. Pulse tx_done; expect return to WAIT_A.
- Level flag: hold rx_done high for 50 cycles per byte with 0x0A, 0x04, 0x22. Expect exactly three captures, tx_data=0x06, and overrun=0.
- Overrun: after the opcode, before tx_done, send byte 0x77. Expect overrun=1 (sticky), alu_a still 0x05. Next frame 0x01, 0x01, 0x20 gives tx_data=0x02.
- Reset mid-frame: send 0x09, 0x02, then assert reset. Expect all outputs 0. Hold rx_done high across reset release; expect no capture until rx_done toggles. Then 0x02, 0x02, 0x20 gives tx_data=0x04.
- Wrap: 0xFF, 0x01, 0x20 gives tx_data=0x00 (bench ALU truncates to 8 bits). 0x00, 0x01, 0x22 gives tx_data=0xFF.
- Timeout (macro defined, TIMEOUT_CYCLES=16): send 0x05 only, then idle. Expect err pulse exactly 15 cycles after the WAIT_B entry edge and return to WAIT_A. Without the macro, err stays 0 and the FSM remains in WAIT_B.
